otter_dmem_arbiter: RTL and testbench

- Two-requester arbiter for the OTTER data memory port (MEM_ADDR2/MEM_DIN2/MEM_WE2/MEM_RDEN2/MEM_SIZE/MEM_SIGN/MEM_DOUT2).
- Requester A is the pipeline MEM stage; requester B is the program loader/DMA engine.
- Grants one access per cycle, steers the winner onto the memory port and returns read data with a per-requester valid strobe.
- Bounds each owner's burst length so neither side starves.

---
 rtl/otter_arb_pkg.sv | 20 ++
 rtl/otter_arb_rdtag.sv | 46 ++++
 rtl/otter_dmem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_otter_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_arb_pkg.sv
// Shared types for the OTTER data-memory arbiter: FSM states, owner tags and
// memory access size codes.
package otter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/otter_arb_rdtag.sv
// Delay line of {valid, owner} read tags; a tag leaves the far end on the
// cycle its memory read data becomes valid.
module otter_arb_rdtag
  import otter_arb_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic   clk,
  input  logic   clr,
  input  logic   in_valid,
  input  owner_t in_owner,
  output logic   out_valid,
  output owner_t out_owner
);

  logic [READ_LAT-1:0] vld_q;
  logic [READ_LAT-1:0] vld_d;
  logic [READ_LAT-1:0] own_q;
  logic [READ_LAT-1:0] own_d;

  // Shift one stage per cycle; a clear flushes every pending tag.
  always_comb begin
    vld_d = '0;
    own_d = '0;
    if (!clr) begin
      vld_d[0] = in_valid;
      own_d[0] = in_owner;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        own_d[i] = own_q[i-1];
      end
    end else begin
      vld_d = '0;
      own_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    vld_q <= vld_d;
    own_q <= own_d;
  end

  assign out_valid = vld_q[READ_LAT-1];
  assign out_owner = owner_t'(own_q[READ_LAT-1]);

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Two-requester arbiter for the OTTER data-memory port: pipeline MEM stage (A)
// versus loader/DMA (B), with burst-bounded ownership and tagged read return.
module otter_dmem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_REQ,
  input  logic        A_WE,
  input  logic [31:0] A_ADDR,
  input  logic [31:0] A_DIN,
  input  logic [1:0]  A_SIZE,
  input  logic        A_SIGN,
  output logic        A_GNT,
  output logic        A_RVALID,
  output logic [31:0] A_RDATA,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [31:0] B_ADDR,
  input  logic [31:0] B_DIN,
  input  logic [1:0]  B_SIZE,
  input  logic        B_SIGN,
  output logic        B_GNT,
  output logic        B_RVALID,
  output logic [31:0] B_RDATA,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  output logic        BUSY
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  owner_t           rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [31:0]      addr_q, addr_d, din_q, din_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [31:0]      a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic             gnt_a, gnt_b, at_max;
  logic             tag_vld;
  owner_t           tag_owner;

  assign at_max = (burst_cnt_q == CNT_W'(MAX_BURST));

  // Grant selection and next ownership; the owner yields only once its burst
  // is spent and the other side is actually waiting.
  always_comb begin
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (A_REQ && (!B_REQ || rr_ptr_q == OWNER_A)) gnt_a = 1'b1;
        else if (B_REQ) gnt_b = 1'b1;
        else gnt_a = 1'b0;
      end
      OWN_A: begin
        if (A_REQ && !(B_REQ && at_max)) gnt_a = 1'b1;
        else if (B_REQ) gnt_b = 1'b1;
        else gnt_a = 1'b0;
      end
      OWN_B: begin
        if (B_REQ && !(A_REQ && at_max)) gnt_b = 1'b1;
        else if (A_REQ) gnt_a = 1'b1;
        else gnt_b = 1'b0;
      end
      default: begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
      end
    endcase
    if (RST) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else begin
      gnt_a = gnt_a;
    end
    if (gnt_a) begin
      if (state_q == OWN_A) begin
        burst_cnt_d = at_max ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
      end else begin
        state_d     = OWN_A;
        burst_cnt_d = CNT_W'(1);
        rr_ptr_d    = OWNER_B;
      end
    end else if (gnt_b) begin
      if (state_q == OWN_B) begin
        burst_cnt_d = at_max ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
      end else begin
        state_d     = OWN_B;
        burst_cnt_d = CNT_W'(1);
        rr_ptr_d    = OWNER_A;
      end
    end else begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end
  end

  // Steer the winner onto the memory port; address/data/size park on the last
  // driven value when nobody is granted.
  always_comb begin
    MEM_WE2   = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_ADDR2 = addr_q;
    MEM_DIN2  = din_q;
    MEM_SIZE  = size_q;
    MEM_SIGN  = sign_q;
    if (gnt_a) begin
      MEM_WE2   = A_WE;
      MEM_RDEN2 = !A_WE;
      MEM_ADDR2 = A_ADDR;
      MEM_DIN2  = A_DIN;
      MEM_SIZE  = A_SIZE;
      MEM_SIGN  = A_SIGN;
    end else if (gnt_b) begin
      MEM_WE2   = B_WE;
      MEM_RDEN2 = !B_WE;
      MEM_ADDR2 = B_ADDR;
      MEM_DIN2  = B_DIN;
      MEM_SIZE  = B_SIZE;
      MEM_SIGN  = B_SIGN;
    end else begin
      MEM_WE2   = 1'b0;
      MEM_RDEN2 = 1'b0;
    end
  end

  otter_arb_rdtag #(.READ_LAT(READ_LAT)) u_rdtag (
    .clk      (CLK),
    .clr      (RST),
    .in_valid ((gnt_a && !A_WE) || (gnt_b && !B_WE)),
    .in_owner (gnt_b ? OWNER_B : OWNER_A),
    .out_valid(tag_vld),
    .out_owner(tag_owner)
  );

  // Returning tags in a reset cycle are dropped so no stale read escapes.
  assign A_RVALID  = tag_vld && !RST && (tag_owner == OWNER_A);
  assign B_RVALID  = tag_vld && !RST && (tag_owner == OWNER_B);
  assign A_RDATA   = A_RVALID ? MEM_DOUT2 : a_rdata_q;
  assign B_RDATA   = B_RVALID ? MEM_DOUT2 : b_rdata_q;
  assign a_rdata_d = A_RDATA;
  assign b_rdata_d = B_RDATA;
  assign addr_d    = MEM_ADDR2;
  assign din_d     = MEM_DIN2;
  assign size_d    = MEM_SIZE;
  assign sign_d    = MEM_SIGN;
  assign A_GNT     = gnt_a;
  assign B_GNT     = gnt_b;
  assign BUSY      = (state_q != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= OWNER_A;
      burst_cnt_q <= '0;
      addr_q      <= 32'h0;
      din_q       <= 32'h0;
      size_q      <= SIZE_WORD;
      sign_q      <= 1'b0;
      a_rdata_q   <= 32'h0;
      b_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Bench for otter_dmem_arbiter: directed scenarios plus random traffic, all
// checked against a rule-level arbitration model and a shadow memory.
module tb_otter_dmem_arbiter;

  localparam int MAX_BURST = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        A_REQ = 1'b0, A_WE = 1'b0, A_SIGN = 1'b0;
  logic [31:0] A_ADDR = 32'h0, A_DIN = 32'h0;
  logic [1:0]  A_SIZE = 2'd2;
  logic        B_REQ = 1'b0, B_WE = 1'b0, B_SIGN = 1'b1;
  logic [31:0] B_ADDR = 32'h0, B_DIN = 32'h0;
  logic [1:0]  B_SIZE = 2'd2;
  logic        A_GNT, A_RVALID, B_GNT, B_RVALID;
  logic [31:0] A_RDATA, B_RDATA;
  logic        MEM_RDEN2, MEM_WE2, MEM_SIGN, BUSY;
  logic [31:0] MEM_ADDR2, MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_DOUT2 = 32'h0;

  otter_dmem_arbiter #(.READ_LAT(1), .MAX_BURST(MAX_BURST)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_SIZE(A_SIZE),
    .A_SIGN(A_SIGN), .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DIN(B_DIN), .B_SIZE(B_SIZE),
    .B_SIGN(B_SIGN), .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
    .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Data memory: one access per cycle, read data valid after the next posedge.
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  always @(posedge CLK) begin
    if (MEM_WE2) begin
      case (MEM_SIZE)
        2'd0:    mem[MEM_ADDR2[11:2]][{MEM_ADDR2[1:0], 3'b000} +: 8] <= MEM_DIN2[7:0];
        2'd1:    mem[MEM_ADDR2[11:2]][{MEM_ADDR2[1], 4'b0000} +: 16] <= MEM_DIN2[15:0];
        default: mem[MEM_ADDR2[11:2]] <= MEM_DIN2;
      endcase
    end else if (MEM_RDEN2) begin
      MEM_DOUT2 <= mem[MEM_ADDR2[11:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: owner 0 none / 1 A / 2 B, run = consecutive grants.
  int          m_owner = 0, m_run = 0, m_pref = 1;
  bit          pend_v = 1'b0;
  int          pend_who = 0;
  logic [31:0] pend_data = 32'h0, last_a = 32'h0, last_b = 32'h0;
  logic [31:0] shadow [0:1023] = '{default: 32'h0};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sh_write(input logic [31:0] addr, input logic [31:0] din, input logic [1:0] sz);
    logic [31:0] w;
    w = shadow[addr[11:2]];
    if (sz == 2'd0) w[8*int'(addr[1:0]) +: 8] = din[7:0];
    else if (sz == 2'd1) w[16*int'(addr[1]) +: 16] = din[15:0];
    else w = din;
    shadow[addr[11:2]] = w;
  endtask

  // One clock cycle: drive, check combinational outputs, then advance the model.
  task automatic cycle(input bit rst,
                       input bit ar, input bit aw, input logic [31:0] aa, input logic [31:0] ad, input logic [1:0] as,
                       input bit br, input bit bw, input logic [31:0] ba, input logic [31:0] bd, input logic [1:0] bs);
    int win;
    bit ev_a, ev_b, wwe;
    logic [31:0] waddr, wdin;
    logic [1:0] wsz;
    @(negedge CLK);
    RST = rst;
    A_REQ = ar; A_WE = aw; A_ADDR = aa; A_DIN = ad; A_SIZE = as;
    B_REQ = br; B_WE = bw; B_ADDR = ba; B_DIN = bd; B_SIZE = bs;
    #1;
    if (rst || (!ar && !br)) win = 0;
    else if (ar && !br) win = 1;
    else if (br && !ar) win = 2;
    else if (m_owner == 0) win = m_pref;
    else if (m_run >= MAX_BURST) win = 3 - m_owner;
    else win = m_owner;
    wwe   = (win == 1) ? aw : bw;
    waddr = (win == 1) ? aa : ba;
    wdin  = (win == 1) ? ad : bd;
    wsz   = (win == 1) ? as : bs;
    chk1("busy", BUSY, m_owner != 0);
    chk1("a_gnt", A_GNT, win == 1);
    chk1("b_gnt", B_GNT, win == 2);
    chk1("mem_we", MEM_WE2, (win != 0) && wwe);
    chk1("mem_rden", MEM_RDEN2, (win != 0) && !wwe);
    if (win != 0) begin
      chk32("mem_addr", MEM_ADDR2, waddr);
      chk32("mem_din", MEM_DIN2, wdin);
      chk32("mem_size", {30'h0, MEM_SIZE}, {30'h0, wsz});
      chk1("mem_sign", MEM_SIGN, win == 2);
    end
    ev_a = pend_v && (pend_who == 1) && !rst;
    ev_b = pend_v && (pend_who == 2) && !rst;
    chk1("a_rvalid", A_RVALID, ev_a);
    chk1("b_rvalid", B_RVALID, ev_b);
    chk32("a_rdata", A_RDATA, ev_a ? pend_data : last_a);
    chk32("b_rdata", B_RDATA, ev_b ? pend_data : last_b);
    if (rst) begin
      last_a = 32'h0; last_b = 32'h0;
      m_owner = 0; m_run = 0; m_pref = 1; pend_v = 1'b0;
    end else begin
      if (ev_a) last_a = pend_data;
      if (ev_b) last_b = pend_data;
      pend_v = 1'b0;
      if (win != 0) begin
        if (wwe) sh_write(waddr, wdin, wsz);
        else begin
          pend_v = 1'b1; pend_who = win; pend_data = shadow[waddr[11:2]];
        end
        if (win == m_owner) m_run++;
        else begin
          m_owner = win; m_run = 1; m_pref = 3 - win;
        end
      end else begin
        m_owner = 0; m_run = 0;
      end
    end
  endtask

  task automatic idle(input bit rst);
    cycle(rst, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
  endtask

  initial begin
    int a_cnt, first_b, b_cnt, rden_seen;
    // Reset: a read requested during reset is neither granted nor returned.
    cycle(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
    cycle(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
    idle(1'b0);

    // A alone: preload 0x100, read it back.
    cycle(1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
    cycle(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
    chk32("t1_addr", MEM_ADDR2, 32'h100);
    idle(1'b0);
    chk1("t1_rvalid", A_RVALID, 1'b1);
    chk32("t1_rdata", A_RDATA, 32'hDEADBEEF);
    chk1("t1_b_rvalid", B_RVALID, 1'b0);

    // Both request from IDLE after reset: A first, run of exactly MAX_BURST.
    idle(1'b1);
    a_cnt = 0; first_b = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b1, 1'b0, 32'h104, 32'h0, 2'd2);
      if (first_b < 0 && B_GNT) first_b = i;
      if (first_b < 0 && A_GNT) a_cnt++;
    end
    chk32("t2_a_run", 32'(a_cnt), 32'd8);
    chk32("t2_first_b", 32'(first_b), 32'd8);

    // Continuous byte writes from both sides.
    idle(1'b1);
    rden_seen = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 32'h200, 32'h11, 2'd0, 1'b1, 1'b1, 32'h204, 32'h22, 2'd0);
      if (MEM_RDEN2) rden_seen++;
    end
    chk32("t3_rden", 32'(rden_seen), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
    idle(1'b0);
    chk32("t3_rd_a", A_RDATA, 32'h11);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b1, 1'b0, 32'h204, 32'h0, 2'd2);
    idle(1'b0);
    chk32("t3_rd_b", B_RDATA, 32'h22);

    // Interleaved reads on consecutive cycles.
    cycle(1'b0, 1'b1, 1'b1, 32'h10, 32'hA5A50010, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
    cycle(1'b0, 1'b1, 1'b1, 32'h14, 32'h5A5A0014, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
    idle(1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 1'b0, 32'h14, 32'h0, 2'd2);
    chk1("t4_a_gnt", A_GNT, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b1, 1'b0, 32'h14, 32'h0, 2'd2);
    chk1("t4_a_rv", A_RVALID, 1'b1);
    chk32("t4_a_rd", A_RDATA, 32'hA5A50010);
    idle(1'b0);
    chk1("t4_b_rv", B_RVALID, 1'b1);
    chk1("t4_a_rv_off", A_RVALID, 1'b0);
    chk32("t4_b_rd", B_RDATA, 32'h5A5A0014);

    // Reset right after a B read grant suppresses its return.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b1, 1'b0, 32'h14, 32'h0, 2'd2);
    idle(1'b1);
    chk1("t5_rv_rst", B_RVALID, 1'b0);
    idle(1'b0);
    chk1("t5_rv_after", B_RVALID, 1'b0);
    chk1("t5_busy", BUSY, 1'b0);
    chk1("t5_we", MEM_WE2, 1'b0);
    chk1("t5_rden", MEM_RDEN2, 1'b0);

    // Lone requester keeps the grant past the burst limit.
    b_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b1, 1'b1, 32'h300, 32'(i), 2'd2);
      if (B_GNT) b_cnt++;
    end
    chk32("t6_b_grants", 32'(b_cnt), 32'd12);
    idle(1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
            32'($urandom), 2'd2,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
            32'($urandom), 2'd2);
    end
    idle(1'b0);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
